// File: rtl/mem_ext_xf.sv
// Memory-extension / interrupt-control unit: IF/IB/DF field registers with extension bits,
// masked priority interrupts and user-mode traps (enabled by MEM_EXT_TIMESHARE_EN).
// Major state encoding: state = {major[2:0], minor[1:0]} with major F=0, D=1, E=2, H=3.
`timescale 1ns/1ps
module mem_ext_xf #(
  parameter int FIELD_W = 3,
  parameter int IRQ_N   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        instruction,
  input  logic [11:0]        ac,
  input  logic [11:0]        sr,
  input  logic [4:0]         state,
  input  logic               clear,
  input  logic               extd_addrd,
  input  logic               gtf,
  input  logic               int_in_prog,
  input  logic [IRQ_N-1:0]   irq,
  output logic               int_ena,
  output logic               int_inh,
  output logic               int_req,
  output logic [3:0]         irq_id,
  output logic               mskip,
  output logic               UF,
  output logic               UI,
  output logic [FIELD_W-1:0] IF,
  output logic [FIELD_W-1:0] DF,
  output logic [11:0]        me_bus
);
  localparam int XW  = FIELD_W - 3;
  localparam int XBW = (XW > 0) ? XW : 1;
  localparam int SW  = 1 + 2 * FIELD_W;
`ifdef MEM_EXT_TIMESHARE_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam logic [4:0] ST_F1 = 5'd1, ST_F2 = 5'd2, ST_F3 = 5'd3, ST_D2 = 5'd6;
  localparam logic [4:0] ST_E0 = 5'd8, ST_E2 = 5'd10, ST_H1 = 5'd13;

  logic [FIELD_W-1:0] if_q, if_d, ib_q, ib_d, df_q, df_d;
  logic [XBW-1:0]     xb_q, xb_d;
  logic [SW-1:0]      sav_q, sav_d;
  logic [IRQ_N-1:0]   mask_q, mask_d;
  logic               uf_q, uf_d, ub_q, ub_d, ui_q, ui_d;
  logic               ena_q, ena_d, dly_q, dly_d, inh_q, inh_d, mskip_q, mskip_d;
  logic [11:0]        bus_q, bus_d;

  logic [2:0]         op;
  logic               iot, kern, trap, srq, cdf_cif, jump;
  logic [IRQ_N-1:0]   act;
  logic [FIELD_W-1:0] new_field, sav_if, sav_df;
  logic               sav_uf;
  logic               unused_sr;

  assign op        = instruction[11:9];
  assign iot       = (op == 3'o6);
  assign kern      = ~uf_q;
  // User-mode trap: any IOT, or a group-2 operate carrying HLT or OSR.
  assign trap      = TS_EN && uf_q && (iot || (op == 3'o7 && instruction[8] && !instruction[0] &&
                                               (instruction[1] || instruction[2])));
  assign act       = irq & mask_q;
  assign srq       = |act;
  assign cdf_cif   = iot && (instruction[8:6] == 3'o2) && (instruction[2:0] != 3'd0) && !instruction[2];
  assign new_field = (FIELD_W'(xb_q) << 3) | FIELD_W'(instruction[5:3]);
  assign sav_uf    = sav_q[SW-1];
  assign sav_if    = sav_q[2*FIELD_W-1:FIELD_W];
  assign sav_df    = sav_q[FIELD_W-1:0];
  assign unused_sr = ^sr[11:6];

  always_comb begin
    if_d = if_q; ib_d = ib_q; df_d = df_q; xb_d = xb_q; sav_d = sav_q; mask_d = mask_q;
    uf_d = uf_q; ub_d = ub_q; ui_d = ui_q; ena_d = ena_q; dly_d = dly_q; inh_d = inh_q;
    mskip_d = mskip_q; bus_d = bus_q; jump = 1'b0;
    case (state)
      ST_F1: begin
        if ((instruction == 12'o6000 && kern && ena_q) || (instruction == 12'o6003 && kern && srq) ||
            (instruction == 12'o6006 && gtf) || (TS_EN && instruction == 12'o6254 && kern && ui_q))
          mskip_d = 1'b1;
      end
      ST_F2: begin
        if (dly_q) begin
          ena_d = 1'b1;
          dly_d = 1'b0;
        end
        if (trap) ui_d = 1'b1;
        else if (kern) begin
          case (instruction)
            12'o6004: bus_d = {2'b00, srq, 1'b0, ena_q | dly_q, sav_q[6:0]};
            12'o6214: bus_d = ac | {6'd0, df_q[2:0], 3'd0};
            12'o6224: bus_d = ac | {6'd0, if_q[2:0], 3'd0};
            12'o6234: bus_d = ac | {5'd0, sav_uf, sav_if[2:0], sav_df[2:0]};
            12'o6245: bus_d = ac | (12'(df_q >> 3) << XW) | 12'(if_q >> 3);
            default: ;
          endcase
        end
        jump = (op == 3'o5) && !instruction[8] && inh_q;
      end
      ST_F3: begin
        mskip_d = 1'b0;
        if (kern && iot) begin
          case (instruction)
            12'o6001: dly_d = 1'b1;
            12'o6000, 12'o6002: begin
              ena_d = 1'b0;
              dly_d = 1'b0;
            end
            12'o6005: begin
              ub_d  = TS_EN ? ac[6] : 1'b0;
              ib_d  = (sav_if & ~FIELD_W'(3'd7)) | FIELD_W'(ac[5:3]);
              df_d  = (sav_df & ~FIELD_W'(3'd7)) | FIELD_W'(ac[2:0]);
              dly_d = 1'b1;
              inh_d = 1'b1;
            end
            12'o6007: begin
              ena_d  = 1'b0;
              dly_d  = 1'b0;
              uf_d   = 1'b0;
              ui_d   = 1'b0;
              mask_d = '1;
            end
            12'o6205: if (XW > 0) xb_d = ac[XBW-1:0];
            12'o6215: mask_d = ac[IRQ_N-1:0];
            12'o6244: begin
              ub_d  = TS_EN ? sav_uf : 1'b0;
              ib_d  = sav_if;
              df_d  = sav_df;
              inh_d = 1'b1;
            end
            12'o6264: if (TS_EN) ub_d = 1'b0;
            12'o6274: if (TS_EN) begin
              ub_d  = 1'b1;
              inh_d = 1'b1;
            end
            12'o6204: if (TS_EN) ui_d = 1'b0;
            default: if (cdf_cif) begin
              if (instruction[0]) df_d = new_field;
              if (instruction[1]) begin
                ib_d  = new_field;
                inh_d = 1'b1;
              end
            end
          endcase
        end
      end
      ST_D2: jump = (op == 3'o5) && inh_q;
      ST_E2: jump = (op == 3'o4) && inh_q;
      ST_E0: if (int_in_prog) begin
        sav_d = {uf_q, if_q, df_q};
        if_d  = '0;
        ib_d  = '0;
        df_d  = '0;
        uf_d  = 1'b0;
        ub_d  = 1'b0;
        ena_d = 1'b0;
        dly_d = 1'b0;
      end
      ST_H1: if (extd_addrd) begin
        if_d = FIELD_W'(sr[5:3]);
        ib_d = FIELD_W'(sr[5:3]);
        df_d = FIELD_W'(sr[2:0]);
        uf_d = 1'b0;
        ub_d = 1'b0;
      end
      default: ;
    endcase
    // A pending CIF/RTF/RMF/SUF is committed by the next JMP/JMS.
    if (jump) begin
      if_d  = ib_q;
      uf_d  = ub_q;
      inh_d = 1'b0;
    end
    if (clear) begin
      if_d = '0; ib_d = '0; df_d = '0; xb_d = '0; sav_d = '0; mask_d = '1;
      uf_d = 1'b0; ub_d = 1'b0; ui_d = 1'b0; ena_d = 1'b0; dly_d = 1'b0; inh_d = 1'b0;
      mskip_d = 1'b0; bus_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_q <= '0; ib_q <= '0; df_q <= '0; xb_q <= '0; sav_q <= '0; mask_q <= '1;
      uf_q <= 1'b0; ub_q <= 1'b0; ui_q <= 1'b0; ena_q <= 1'b0; dly_q <= 1'b0; inh_q <= 1'b0;
      mskip_q <= 1'b0; bus_q <= '0;
    end else begin
      if_q <= if_d; ib_q <= ib_d; df_q <= df_d; xb_q <= xb_d; sav_q <= sav_d; mask_q <= mask_d;
      uf_q <= uf_d; ub_q <= ub_d; ui_q <= ui_d; ena_q <= ena_d; dly_q <= dly_d; inh_q <= inh_d;
      mskip_q <= mskip_d; bus_q <= bus_d;
    end
  end

  // Lowest-numbered active line wins; scan downward so it is assigned last.
  always_comb begin
    irq_id = 4'd0;
    for (int i = IRQ_N - 1; i >= 0; i--)
      if (act[i]) irq_id = 4'(i);
  end

  assign int_req = ena_q & ~inh_q & srq;
  assign int_ena = ena_q;
  assign int_inh = inh_q;
  assign mskip   = mskip_q;
  assign UF      = TS_EN ? uf_q : 1'b0;
  assign UI      = TS_EN ? ui_q : 1'b0;
  assign IF      = if_q;
  assign DF      = df_q;
  assign me_bus  = bus_q;
endmodule

// File: tb/tb_mem_ext_xf.sv
// Directed bench for mem_ext_xf (FIELD_W=4, IRQ_N=4); user-mode cases follow MEM_EXT_TIMESHARE_EN.
`timescale 1ns/1ps
module tb_mem_ext_xf;
  localparam logic [4:0] F0 = 5'd0, F1 = 5'd1, F2 = 5'd2, F3 = 5'd3;
  localparam logic [4:0] D0 = 5'd4, D1 = 5'd5, D2 = 5'd6, D3 = 5'd7, E0 = 5'd8, H1 = 5'd13;

  logic        clk = 1'b0;
  logic        reset, clear, extd_addrd, gtf, int_in_prog;
  logic [11:0] instruction, ac, sr;
  logic [4:0]  state;
  logic [3:0]  irq;
  logic        int_ena, int_inh, int_req, mskip, UF, UI;
  logic [3:0]  irq_id, IF, DF;
  logic [11:0] me_bus;
  int total = 0;
  int bad = 0;

  mem_ext_xf #(.FIELD_W(4), .IRQ_N(4)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .ac(ac), .sr(sr), .state(state),
    .clear(clear), .extd_addrd(extd_addrd), .gtf(gtf), .int_in_prog(int_in_prog), .irq(irq),
    .int_ena(int_ena), .int_inh(int_inh), .int_req(int_req), .irq_id(irq_id), .mskip(mskip),
    .UF(UF), .UI(UI), .IF(IF), .DF(DF), .me_bus(me_bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [4:0] st);
    @(negedge clk); state = st;
    @(posedge clk); #1;
  endtask

  task automatic fetch_to_f2(input logic [11:0] ins, input logic [11:0] a);
    instruction = ins; ac = a;
    step(F0); step(F1); step(F2);
  endtask

  task automatic do_f3();
    step(F3);
  endtask

  task automatic instr(input logic [11:0] ins, input logic [11:0] a);
    fetch_to_f2(ins, a);
    do_f3();
  endtask

  task automatic test_reset();
    reset = 1'b0; irq = 4'b0100;
    repeat (2) @(posedge clk);
    #1;
    total++; if (int_ena !== 1'b0) begin bad++; $display("FAIL rst_int_ena got=%b exp=0", int_ena); end
    total++; if (int_inh !== 1'b0) begin bad++; $display("FAIL rst_int_inh got=%b exp=0", int_inh); end
    total++; if (mskip !== 1'b0) begin bad++; $display("FAIL rst_mskip got=%b exp=0", mskip); end
    total++; if ({IF, DF} !== 8'h00) begin bad++; $display("FAIL rst_if_df got=%h exp=00", {IF, DF}); end
    total++; if (me_bus !== 12'o0000) begin bad++; $display("FAIL rst_me_bus got=%o exp=0", me_bus); end
    total++; if ({UF, UI} !== 2'b00) begin bad++; $display("FAIL rst_uf_ui got=%b exp=00", {UF, UI}); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rst_int_req got=%b exp=0", int_req); end
    total++; if (irq_id !== 4'd2) begin bad++; $display("FAIL rst_mask_ones irq_id got=%0d exp=2", irq_id); end
    @(negedge clk); reset = 1'b1; irq = 4'b0000;
  endtask

  task automatic test_field_ext();
    instr(12'o6205, 12'o0001);
    instr(12'o6213, 12'o0000);
    total++; if (DF !== 4'b1001) begin bad++; $display("FAIL cdf_df got=%b exp=1001", DF); end
    total++; if (IF !== 4'b0000) begin bad++; $display("FAIL cif_if_before_jmp got=%b exp=0000", IF); end
    total++; if (int_inh !== 1'b1) begin bad++; $display("FAIL cif_inh got=%b exp=1", int_inh); end
    instr(12'o5200, 12'o0000);
    total++; if (IF !== 4'b1001) begin bad++; $display("FAIL jmp_if got=%b exp=1001", IF); end
    total++; if (int_inh !== 1'b0) begin bad++; $display("FAIL jmp_inh got=%b exp=0", int_inh); end
    instr(12'o6245, 12'o0000);
    total++; if (me_bus !== 12'o0003) begin bad++; $display("FAIL rxf got=%o exp=0003", me_bus); end
    instr(12'o6214, 12'o0000);
    total++; if (me_bus !== 12'o0010) begin bad++; $display("FAIL rdf got=%o exp=0010", me_bus); end
    instr(12'o6224, 12'o7000);
    total++; if (me_bus !== 12'o7010) begin bad++; $display("FAIL rif got=%o exp=7010", me_bus); end
    instr(12'o6205, 12'o0000);
  endtask

  task automatic test_ion();
    instr(12'o6001, 12'o0000);
    total++; if (int_ena !== 1'b0) begin bad++; $display("FAIL ion_f3 got=%b exp=0", int_ena); end
    fetch_to_f2(12'o7000, 12'o0000);
    total++; if (int_ena !== 1'b1) begin bad++; $display("FAIL ion_next_f2 got=%b exp=1", int_ena); end
    do_f3();
    instr(12'o6004, 12'o0000);
    total++; if (me_bus !== 12'o0200) begin bad++; $display("FAIL gtf_ion got=%o exp=0200", me_bus); end
    instr(12'o6002, 12'o0000);
    total++; if (int_ena !== 1'b0) begin bad++; $display("FAIL iof got=%b exp=0", int_ena); end
    instr(12'o6001, 12'o0000);
    fetch_to_f2(12'o6002, 12'o0000);
    total++; if (int_ena !== 1'b1) begin bad++; $display("FAIL expiry_f2 got=%b exp=1", int_ena); end
    do_f3();
    total++; if (int_ena !== 1'b0) begin bad++; $display("FAIL iof_wins got=%b exp=0", int_ena); end
    instr(12'o6004, 12'o0000);
    total++; if (me_bus !== 12'o0000) begin bad++; $display("FAIL gtf_iof got=%o exp=0000", me_bus); end
    instr(12'o6001, 12'o0000);
    instr(12'o7000, 12'o0000);
    fetch_to_f2(12'o6000, 12'o0000);
    total++; if (mskip !== 1'b1) begin bad++; $display("FAIL skon_skip got=%b exp=1", mskip); end
    do_f3();
    total++; if ({mskip, int_ena} !== 2'b00) begin bad++; $display("FAIL skon_f3 got=%b exp=00", {mskip, int_ena}); end
  endtask

  task automatic test_irq();
    instr(12'o6215, 12'o0006);
    instr(12'o6001, 12'o0000);
    instr(12'o7000, 12'o0000);
    irq = 4'b1110; #1;
    total++; if ({int_req, irq_id} !== 5'b1_0001) begin bad++; $display("FAIL irq_1110 got=%b exp=10001", {int_req, irq_id}); end
    irq = 4'b1000; #1;
    total++; if ({int_req, irq_id} !== 5'b0_0000) begin bad++; $display("FAIL irq_1000 got=%b exp=00000", {int_req, irq_id}); end
    irq = 4'b0100; #1;
    total++; if ({int_req, irq_id} !== 5'b1_0010) begin bad++; $display("FAIL irq_0100 got=%b exp=10010", {int_req, irq_id}); end
    fetch_to_f2(12'o6003, 12'o0000);
    total++; if (mskip !== 1'b1) begin bad++; $display("FAIL srq_skip got=%b exp=1", mskip); end
    do_f3();
    instr(12'o6202, 12'o0000);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL inh_blocks_req got=%b exp=0", int_req); end
    instr(12'o5200, 12'o0000);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL req_after_jmp got=%b exp=1", int_req); end
    instr(12'o6007, 12'o0000);
    irq = 4'b1000; #1;
    total++; if ({int_req, irq_id} !== 5'b0_0011) begin bad++; $display("FAIL caf got=%b exp=00011", {int_req, irq_id}); end
    irq = 4'b0000;
  endtask

  task automatic test_save_restore();
    sr = 12'o0053; extd_addrd = 1'b1;
    step(H1);
    extd_addrd = 1'b0;
    total++; if ({IF, DF} !== 8'h53) begin bad++; $display("FAIL extd_addr got=%h exp=53", {IF, DF}); end
    int_in_prog = 1'b1;
    step(E0);
    int_in_prog = 1'b0;
    total++; if ({IF, DF} !== 8'h00) begin bad++; $display("FAIL int_entry got=%h exp=00", {IF, DF}); end
    instr(12'o6234, 12'o0000);
    total++; if (me_bus !== 12'o0053) begin bad++; $display("FAIL rib got=%o exp=0053", me_bus); end
    instr(12'o6004, 12'o0000);
    total++; if (me_bus !== 12'o0123) begin bad++; $display("FAIL gtf_save got=%o exp=0123", me_bus); end
    instr(12'o6244, 12'o0000);
    total++; if ({int_inh, IF, DF} !== 9'b1_0000_0011) begin bad++; $display("FAIL rmf got=%b exp=100000011", {int_inh, IF, DF}); end
    instr(12'o5200, 12'o0000);
    total++; if ({int_inh, IF} !== 5'b0_0101) begin bad++; $display("FAIL rmf_jmp got=%b exp=00101", {int_inh, IF}); end
    instr(12'o6005, 12'o0025);
    total++; if ({int_ena, DF} !== 5'b0_0101) begin bad++; $display("FAIL rtf got=%b exp=00101", {int_ena, DF}); end
    fetch_to_f2(12'o5200, 12'o0000);
    total++; if ({int_ena, IF} !== 5'b1_0010) begin bad++; $display("FAIL rtf_jmp got=%b exp=10010", {int_ena, IF}); end
    do_f3();
    instr(12'o6002, 12'o0000);
  endtask

  task automatic test_sgt();
    gtf = 1'b1;
    fetch_to_f2(12'o6006, 12'o0000);
    total++; if (mskip !== 1'b1) begin bad++; $display("FAIL sgt_set got=%b exp=1", mskip); end
    do_f3();
    gtf = 1'b0;
    fetch_to_f2(12'o6006, 12'o0000);
    total++; if (mskip !== 1'b0) begin bad++; $display("FAIL sgt_clr got=%b exp=0", mskip); end
    do_f3();
  endtask

  task automatic test_user_mode();
`ifdef MEM_EXT_TIMESHARE_EN
    instr(12'o6274, 12'o0000);
    total++; if (int_inh !== 1'b1) begin bad++; $display("FAIL suf_inh got=%b exp=1", int_inh); end
    instr(12'o5200, 12'o0000);
    total++; if (UF !== 1'b1) begin bad++; $display("FAIL suf_jmp_uf got=%b exp=1", UF); end
    instr(12'o6001, 12'o0000);
    total++; if (UI !== 1'b1) begin bad++; $display("FAIL trap_ui got=%b exp=1", UI); end
    fetch_to_f2(12'o7000, 12'o0000);
    total++; if (int_ena !== 1'b0) begin bad++; $display("FAIL trap_no_ion got=%b exp=0", int_ena); end
    do_f3();
    int_in_prog = 1'b1;
    step(E0);
    int_in_prog = 1'b0;
    total++; if (UF !== 1'b0) begin bad++; $display("FAIL entry_uf got=%b exp=0", UF); end
    fetch_to_f2(12'o6254, 12'o0000);
    total++; if (mskip !== 1'b1) begin bad++; $display("FAIL sint_skip got=%b exp=1", mskip); end
    do_f3();
    instr(12'o6204, 12'o0000);
    total++; if (UI !== 1'b0) begin bad++; $display("FAIL cui got=%b exp=0", UI); end
`else
    instr(12'o6274, 12'o0000);
    total++; if (int_inh !== 1'b0) begin bad++; $display("FAIL suf_noop got=%b exp=0", int_inh); end
    instr(12'o5200, 12'o0000);
    total++; if ({UF, UI} !== 2'b00) begin bad++; $display("FAIL uf_tied got=%b exp=00", {UF, UI}); end
    fetch_to_f2(12'o6254, 12'o0000);
    total++; if (mskip !== 1'b0) begin bad++; $display("FAIL sint_noskip got=%b exp=0", mskip); end
    do_f3();
`endif
  endtask

  task automatic test_indirect_jmp();
    instr(12'o6232, 12'o0000);
    instr(12'o5600, 12'o0000);
    total++; if (int_inh !== 1'b1) begin bad++; $display("FAIL ind_jmp_f2 got=%b exp=1", int_inh); end
    step(D0); step(D1); step(D2);
    total++; if ({int_inh, IF} !== 5'b0_0011) begin bad++; $display("FAIL ind_jmp_d2 got=%b exp=00011", {int_inh, IF}); end
    step(D3);
  endtask

  task automatic test_clear();
    instr(12'o6241, 12'o0000);
    total++; if (DF !== 4'd4) begin bad++; $display("FAIL cdf4 got=%0d exp=4", DF); end
    instr(12'o6001, 12'o0000);
    instr(12'o7000, 12'o0000);
    clear = 1'b1;
    step(F0);
    clear = 1'b0;
    total++; if ({int_ena, IF, DF} !== 9'd0) begin bad++; $display("FAIL clear got=%b exp=0", {int_ena, IF, DF}); end
  endtask

  task automatic test_async_reset();
    instr(12'o6001, 12'o0000);
    instr(12'o6212, 12'o0000);
    total++; if (int_inh !== 1'b1) begin bad++; $display("FAIL pre_areset_inh got=%b exp=1", int_inh); end
    @(posedge clk); #2 reset = 1'b0;
    #1;
    total++; if (int_inh !== 1'b0) begin bad++; $display("FAIL areset_inh got=%b exp=0", int_inh); end
    @(negedge clk); reset = 1'b1;
    fetch_to_f2(12'o7000, 12'o0000);
    total++; if (int_ena !== 1'b0) begin bad++; $display("FAIL areset_delay got=%b exp=0", int_ena); end
    do_f3();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; clear = 1'b0; extd_addrd = 1'b0; gtf = 1'b0; int_in_prog = 1'b0;
    instruction = 12'o7000; ac = 12'o0000; sr = 12'o0000; state = F0; irq = 4'b0000;
    test_reset();
    test_field_ext();
    test_ion();
    test_irq();
    test_save_restore();
    test_sgt();
    test_user_mode();
    test_indirect_jmp();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
